// File: rtl/prf_free_list_if.sv
// ---------------------------------------------------------------------------
// prf_free_list_if
//   Groups the allocate (rename) and release (commit) handshakes of the
//   physical register free list into one bundle.
//
//   Allocate side : alloc_req (in), alloc_valid (out), alloc_prf_id (out)
//   Release side  : free_valid (in), free_prf_id (in), free_error (out)
//   Status        : free_count (out), empty (out), full (out)
//
//   Modports:
//     master : the core side (rename + commit), drives requests/releases
//     slave  : the free list itself
// ---------------------------------------------------------------------------
interface prf_free_list_if #(
  parameter int ID_W  = 8,
  parameter int CNT_W = 6
);

  logic             alloc_req;
  logic             alloc_valid;
  logic [ID_W-1:0]  alloc_prf_id;

  logic             free_valid;
  logic [ID_W-1:0]  free_prf_id;
  logic             free_error;

  logic [CNT_W-1:0] free_count;
  logic             empty;
  logic             full;

  modport master (
    output alloc_req,
    input  alloc_valid,
    input  alloc_prf_id,
    output free_valid,
    output free_prf_id,
    input  free_error,
    input  free_count,
    input  empty,
    input  full
  );

  modport slave (
    input  alloc_req,
    output alloc_valid,
    output alloc_prf_id,
    input  free_valid,
    input  free_prf_id,
    output free_error,
    output free_count,
    output empty,
    output full
  );

endinterface

// File: rtl/prf_free_list.sv
// ---------------------------------------------------------------------------
// prf_free_list
//   Circular FIFO of unallocated physical register IDs. Rename pops the head
//   (show-ahead, same-cycle use) for every destination write; commit pushes
//   back the superseded mapping when the owning instruction retires.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset; reloads IDs NUM_ARCH..NUM_PRF-1
//     bus    : prf_free_list_if.slave
//              alloc_req / alloc_valid / alloc_prf_id  - allocate handshake
//              free_valid / free_prf_id / free_error    - release handshake
//              free_count / empty / full                - occupancy status
//
//   Parameters:
//     NUM_PRF  : total physical registers (legal IDs 0..NUM_PRF-1)
//     NUM_ARCH : architectural registers, mapped at reset to PRF 0..NUM_ARCH-1
//     ID_W     : PRF ID width
// ---------------------------------------------------------------------------
module prf_free_list #(
  parameter int NUM_PRF  = 64,
  parameter int NUM_ARCH = 32,
  parameter int ID_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prf_free_list_if.slave       bus
);

  localparam int DEPTH = NUM_PRF - NUM_ARCH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so NUM_PRF itself is representable when NUM_PRF == 2**ID_W.
  localparam logic [ID_W:0]    NUM_PRF_X = (ID_W+1)'(NUM_PRF);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [ID_W-1:0]  entry [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             free_error_q;

  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;

  logic             not_empty;
  logic             is_full;
  logic             grant;
  logic             legal;
  logic             accept;
  logic             drop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Status comes from the count register alone, so there is no
  // combinational path from the request inputs to any status output.
  assign not_empty = (count != '0);
  assign is_full   = (count == DEPTH_C);

  // ID 0 is permanently mapped and IDs at or above NUM_PRF do not exist;
  // both are refused rather than corrupting the list.
  assign legal  = (bus.free_prf_id != '0) && ({1'b0, bus.free_prf_id} < NUM_PRF_X);

  // A release into a full list is still taken when a grant frees a slot in
  // the same cycle. There is no bypass the other way: an empty list never
  // grants, even if a release arrives in the same cycle.
  assign grant  = bus.alloc_req & not_empty;
  assign accept = bus.free_valid & legal & (~is_full | grant);
  assign drop   = bus.free_valid & ~accept;

  // Next-state for pointers and occupancy.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;

    if (grant) begin
      head_next = ptr_inc(head);
    end

    if (accept) begin
      tail_next = ptr_inc(tail);
    end

    unique case ({accept, grant})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointer, counter and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= DEPTH_C;
      free_error_q <= 1'b0;
    end else begin
      head         <= head_next;
      tail         <= tail_next;
      count        <= count_next;
      free_error_q <= drop;
    end
  end

  // Storage reloads the non-architectural IDs in ascending order on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= ID_W'(NUM_ARCH + i);
      end
    end else if (accept) begin
      entry[tail] <= bus.free_prf_id;
    end
  end

  // Show-ahead head; forced to zero when empty so stale entries never leak.
  always_comb begin
    bus.alloc_prf_id = '0;
    if (not_empty) begin
      bus.alloc_prf_id = entry[head];
    end
  end

  assign bus.alloc_valid = not_empty;
  assign bus.free_error  = free_error_q;
  assign bus.free_count  = count;
  assign bus.empty       = ~not_empty;
  assign bus.full        = is_full;

endmodule

// File: tb/tb_prf_free_list.sv
// ---------------------------------------------------------------------------
// tb_prf_free_list
//   Self-checking bench for prf_free_list. A queue of free IDs is the
//   reference: grants pop the front, accepted releases push the back.
//   Directed scenarios come first, then a randomized run with occasional
//   mid-cycle resets.
// ---------------------------------------------------------------------------
module tb_prf_free_list;

  localparam int NUM_PRF  = 64;
  localparam int NUM_ARCH = 32;
  localparam int ID_W     = 8;
  localparam int DEPTH    = NUM_PRF - NUM_ARCH;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;

  prf_free_list_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  prf_free_list #(
    .NUM_PRF (NUM_PRF),
    .NUM_ARCH(NUM_ARCH),
    .ID_W    (ID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared;
  int unsigned mismatched;

  // Reference model: list of free IDs in allocation order.
  int unsigned freeQ[$];
  bit          expErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    freeQ.delete();
    for (int i = NUM_ARCH; i < NUM_PRF; i++) freeQ.push_back(i);
    expErr = 1'b0;
  endtask

  // Compare every observable output against the model.
  task automatic checkAll(input string where);
    int unsigned n;
    n = freeQ.size();
    checkOutput({where, ".valid"}, 32'(bus.alloc_valid), 32'(n != 0));
    checkOutput({where, ".id"},    32'(bus.alloc_prf_id), (n != 0) ? freeQ[0] : 0);
    checkOutput({where, ".count"}, 32'(bus.free_count), n);
    checkOutput({where, ".empty"}, 32'(bus.empty), 32'(n == 0));
    checkOutput({where, ".full"},  32'(bus.full), 32'(n == DEPTH));
    checkOutput({where, ".err"},   32'(bus.free_error), 32'(expErr));
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
  task automatic applyStimulus(input bit req, input bit fv, input logic [ID_W-1:0] id);
    bit grant;
    bit legal;
    bit accept;
    bus.alloc_req   = req;
    bus.free_valid  = fv;
    bus.free_prf_id = id;
    @(negedge clk);
    checkAll("cyc");
    grant  = req && (freeQ.size() != 0);
    legal  = (id != 0) && (int'(id) < NUM_PRF);
    accept = fv && legal && ((freeQ.size() < DEPTH) || grant);
    if (grant)  void'(freeQ.pop_front());
    if (accept) freeQ.push_back(int'(id));
    expErr = fv && !accept;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.alloc_req   = 1'b0;
    bus.free_valid  = 1'b0;
    bus.free_prf_id = '0;
  endtask

  // Reset asserted mid-cycle with an alloc request pending; outputs must
  // reload immediately and the request must be discarded.
  task automatic midReset(input bit withReq);
    bus.alloc_req = withReq;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("rstNow");
    @(posedge clk);
    #1;
    checkAll("rstHeld");
    @(negedge clk);
    rst_n = 1'b1;
    idleInputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    idleInputs();
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset: full list, head = 32.
    checkOutput("rst.id", 32'(bus.alloc_prf_id), 32);
    checkOutput("rst.count", 32'(bus.free_count), 32);
    checkOutput("rst.full", 32'(bus.full), 1);
    applyStimulus(1'b0, 1'b0, '0);

    // Drain: 32 IDs in ascending order, then empty; 33rd request is ignored.
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain.id", 32'(bus.alloc_prf_id), 32'(NUM_ARCH + i));
      applyStimulus(1'b1, 1'b0, '0);
    end
    checkOutput("drain.empty", 32'(bus.empty), 1);
    checkOutput("drain.idZero", 32'(bus.alloc_prf_id), 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("drain.count33", 32'(bus.free_count), 0);

    // Refill from empty, then allocate in FIFO order.
    applyStimulus(1'b0, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b1, 8'd17);
    applyStimulus(1'b0, 1'b1, 8'd40);
    checkOutput("refill.count", 32'(bus.free_count), 3);
    checkOutput("refill.id0", 32'(bus.alloc_prf_id), 5);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("refill.id1", 32'(bus.alloc_prf_id), 17);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("refill.id2", 32'(bus.alloc_prf_id), 40);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("refill.countEnd", 32'(bus.free_count), 0);

    // Simultaneous grant and release at count=1: old head leaves, new ID stays.
    applyStimulus(1'b0, 1'b1, 8'd11);
    applyStimulus(1'b1, 1'b1, 8'd12);
    checkOutput("one.id", 32'(bus.alloc_prf_id), 12);
    checkOutput("one.count", 32'(bus.free_count), 1);

    // Full list with simultaneous grant and release of ID 7.
    midReset(1'b0);
    checkOutput("fullSwap.head", 32'(bus.alloc_prf_id), 32);
    applyStimulus(1'b1, 1'b1, 8'd7);
    checkOutput("fullSwap.count", 32'(bus.free_count), 32);
    checkOutput("fullSwap.err", 32'(bus.free_error), 0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("fullSwap.seven", 32'(bus.alloc_prf_id), 7);

    // Dropped releases: full without grant, then illegal IDs at partial fill.
    midReset(1'b0);
    applyStimulus(1'b0, 1'b1, 8'd9);
    checkOutput("drop.full.err", 32'(bus.free_error), 1);
    checkOutput("drop.full.count", 32'(bus.free_count), 32);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drop.pulseEnd", 32'(bus.free_error), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("drop.id0.err", 32'(bus.free_error), 1);
    applyStimulus(1'b0, 1'b1, 8'd64);
    checkOutput("drop.id64.err", 32'(bus.free_error), 1);
    checkOutput("drop.count", 32'(bus.free_count), 28);
    applyStimulus(1'b0, 1'b1, 8'd63);
    checkOutput("drop.id63.ok", 32'(bus.free_error), 0);

    // Ten allocs, then reset mid-cycle with a request pending.
    midReset(1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("mid.before", 32'(bus.alloc_prf_id), 42);
    midReset(1'b1);
    checkOutput("mid.first", 32'(bus.alloc_prf_id), 32);
    applyStimulus(1'b1, 1'b0, '0);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit v;
      logic [ID_W-1:0] id;
      if ($urandom_range(0, 299) == 0) begin
        midReset($urandom_range(0, 1) == 1);
      end else begin
        r  = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 65 : 35));
        v  = ($urandom_range(0, 99) < 50);
        id = ID_W'($urandom_range(0, 70));
        applyStimulus(r, v, id);
      end
    end

    idleInputs();
    applyStimulus(1'b0, 1'b0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
